digit_entry_ctrl: RTL and testbench

Sequencer for the 4-nibble keypad/switch entry shift register. Turns button presses into single-cycle shift and clear pulses, counts the digits entered and refuses entries past capacity. On "enter" it captures the assembled 16-bit word and offers it downstream (calculator/ALU) with a valid/ready handshake. Sits between the debounced board buttons and the shift-register datapath.

---
 rtl/digit_entry_ctrl_if.sv | 34 +++
 rtl/digit_entry_ctrl.sv | 168 ++++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_ctrl_if.sv
// digit_entry_ctrl_if
//   Bus between the digit entry sequencer and its neighbours: the 4-nibble
//   entry shift register (shift/clear strobes out, current contents back)
//   and the downstream operand consumer (valid/ready handshake).
//   master : sequencer side   slave : shift register / consumer side
//   shift_en      1-cycle shift strobe
//   shift_din     digit presented with shift_en
//   shift_clr     1-cycle clear strobe
//   sr_data       current shift register contents
//   operand       captured word
//   operand_valid operand offered downstream
//   operand_ready downstream accepts operand
interface digit_entry_ctrl_if #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4
);
  logic                          shift_en;
  logic [DIGIT_W-1:0]            shift_din;
  logic                          shift_clr;
  logic [MAX_DIGITS*DIGIT_W-1:0] sr_data;
  logic [MAX_DIGITS*DIGIT_W-1:0] operand;
  logic                          operand_valid;
  logic                          operand_ready;

  modport master (
    output shift_en, shift_din, shift_clr, operand, operand_valid,
    input  sr_data, operand_ready
  );

  modport slave (
    input  shift_en, shift_din, shift_clr, operand, operand_valid,
    output sr_data, operand_ready
  );
endinterface

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl
//   Turns debounced button levels into single-cycle shift/clear strobes for
//   the digit entry shift register, tracks how many digits are held, rejects
//   pushes beyond capacity, and on "enter" captures the assembled word and
//   offers it downstream with a valid/ready handshake.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   i_btn_push      button level; rising edge shifts in i_sw_digit
//   i_btn_clear     button level; rising edge clears the entry
//   i_btn_enter     button level; rising edge submits the entry
//   i_sw_digit      digit value sampled on the push edge
//   o_digit_count   digits currently held
//   o_push_reject   1-cycle pulse when a push is refused (register full)
//   bus             shift register strobes and operand handshake (master)
module digit_entry_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_btn_push,
  input  logic               i_btn_clear,
  input  logic               i_btn_enter,
  input  logic [DIGIT_W-1:0] i_sw_digit,
  output logic [CNT_W-1:0]   o_digit_count,
  output logic               o_push_reject,
  digit_entry_ctrl_if.master bus
);

  localparam int unsigned WORD_W = MAX_DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_ENTRY,
    S_FULL,
    S_CAPTURE,
    S_OFFER
  } state_t;

  state_t              r_state;
  logic                r_push_q;
  logic                r_clear_q;
  logic                r_enter_q;
  logic                r_armed;
  logic [CNT_W-1:0]    r_count;
  logic                r_shift_en;
  logic [DIGIT_W-1:0]  r_shift_din;
  logic                r_shift_clr;
  logic                r_reject;
  logic [WORD_W-1:0]   r_operand;
  logic                r_valid;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [CNT_W-1:0]    w_count_inc;
  logic                w_shift_en_nxt;
  logic [DIGIT_W-1:0]  w_shift_din_nxt;
  logic                w_shift_clr_nxt;
  logic                w_reject_nxt;
  logic [WORD_W-1:0]   w_operand_nxt;
  logic                w_valid_nxt;
  logic                w_clr;
  logic                w_ent;
  logic                w_push;

  // r_armed masks edges for the first cycle after reset so a button already
  // held high at reset release is seen as a level, not a fresh press.
  // Priority clear > enter > push; losers are simply dropped.
  assign w_clr  = r_armed & i_btn_clear & ~r_clear_q;
  assign w_ent  = r_armed & i_btn_enter & ~r_enter_q & ~w_clr;
  assign w_push = r_armed & i_btn_push  & ~r_push_q  & ~w_clr & ~(i_btn_enter & ~r_enter_q);

  assign w_count_inc = r_count + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_shift_en_nxt  = 1'b0;
    w_shift_din_nxt = r_shift_din;
    w_shift_clr_nxt = 1'b0;
    w_reject_nxt    = 1'b0;
    w_operand_nxt   = r_operand;
    w_valid_nxt     = r_valid;
    case (r_state)
      S_EMPTY, S_ENTRY: begin
        if (w_clr) begin
          w_shift_clr_nxt = 1'b1;
          w_count_nxt     = '0;
          w_state_nxt     = S_EMPTY;
        end else if (w_ent) begin
          if (r_state == S_ENTRY) w_state_nxt = S_CAPTURE;
        end else if (w_push) begin
          w_shift_en_nxt  = 1'b1;
          w_shift_din_nxt = i_sw_digit;
          w_count_nxt     = w_count_inc;
          w_state_nxt     = (w_count_inc == CNT_W'(MAX_DIGITS)) ? S_FULL : S_ENTRY;
        end
      end
      S_FULL: begin
        if (w_clr) begin
          w_shift_clr_nxt = 1'b1;
          w_count_nxt     = '0;
          w_state_nxt     = S_EMPTY;
        end else if (w_ent) begin
          w_state_nxt = S_CAPTURE;
        end else if (w_push) begin
          w_reject_nxt = 1'b1;
        end
      end
      // One idle cycle lets a shift strobed in the previous cycle land in
      // sr_data before it is captured.
      S_CAPTURE: begin
        w_operand_nxt = bus.sr_data;
        w_valid_nxt   = 1'b1;
        w_state_nxt   = S_OFFER;
      end
      S_OFFER: begin
        if (w_clr || (r_valid && bus.operand_ready)) begin
          w_valid_nxt     = 1'b0;
          w_shift_clr_nxt = 1'b1;
          w_count_nxt     = '0;
          w_state_nxt     = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_push_q    <= 1'b0;
      r_clear_q   <= 1'b0;
      r_enter_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_count     <= '0;
      r_shift_en  <= 1'b0;
      r_shift_din <= '0;
      r_shift_clr <= 1'b0;
      r_reject    <= 1'b0;
      r_operand   <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_push_q    <= i_btn_push;
      r_clear_q   <= i_btn_clear;
      r_enter_q   <= i_btn_enter;
      r_armed     <= 1'b1;
      r_count     <= w_count_nxt;
      r_shift_en  <= w_shift_en_nxt;
      r_shift_din <= w_shift_din_nxt;
      r_shift_clr <= w_shift_clr_nxt;
      r_reject    <= w_reject_nxt;
      r_operand   <= w_operand_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign o_digit_count     = r_count;
  assign o_push_reject     = r_reject;
  assign bus.shift_en      = r_shift_en;
  assign bus.shift_din     = r_shift_din;
  assign bus.shift_clr     = r_shift_clr;
  assign bus.operand       = r_operand;
  assign bus.operand_valid = r_valid;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Testbench for digit_entry_ctrl: directed scenarios followed by random
// button activity, checked against a digit-list reference model through an
// event scoreboard.
module tb_digit_entry_ctrl;
  localparam int unsigned MAXD = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned CW   = 3;
  localparam int K_SHIFT = 0;
  localparam int K_CLEAR = 1;
  localparam int K_REJECT = 2;
  localparam int K_HAND = 3;

  typedef struct { int kind; logic [15:0] val; } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_push = 1'b0, btn_clear = 1'b0, btn_enter = 1'b0;
  logic [3:0]  sw = '0;
  logic        ready = 1'b0;
  logic [2:0]  count;
  logic        reject;
  logic [15:0] sr;

  int n_chk = 0, n_err = 0;
  int n_shift = 0, n_clr = 0, n_rej = 0, n_valid = 0;

  digit_entry_ctrl_if #(.MAX_DIGITS(MAXD), .DIGIT_W(DW)) bus ();

  digit_entry_ctrl #(.MAX_DIGITS(MAXD), .DIGIT_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_btn_push(btn_push), .i_btn_clear(btn_clear), .i_btn_enter(btn_enter),
    .i_sw_digit(sw), .o_digit_count(count), .o_push_reject(reject),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Downstream shift register driven by the DUT strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else if (bus.shift_clr) sr <= '0;
    else if (bus.shift_en) sr <= {sr[11:0], bus.shift_din};
  end
  assign bus.sr_data       = sr;
  assign bus.operand_ready = ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the entry is a list of digits; the operand is those
  // digits packed first-entered-most-significant.
  logic [3:0]  m_digits[$];
  ev_t         exp_q[$];
  bit          m_first = 1'b1, m_capt = 1'b0, m_offer = 1'b0;
  bit          p_push = 1'b0, p_clr = 1'b0, p_ent = 1'b0;
  bit          e_push, e_clr, e_ent;
  logic [15:0] m_operand = '0;

  function automatic logic [15:0] pack_digits();
    logic [15:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_first = 1'b1; m_capt = 1'b0; m_offer = 1'b0; m_operand = '0;
      p_push = 1'b0; p_clr = 1'b0; p_ent = 1'b0;
      m_digits.delete(); exp_q.delete();
    end else begin
      e_clr  = btn_clear & ~p_clr & ~m_first;
      e_ent  = btn_enter & ~p_ent & ~m_first & ~e_clr;
      e_push = btn_push & ~p_push & ~m_first & ~e_clr & ~(btn_enter & ~p_ent);
      p_push = btn_push; p_clr = btn_clear; p_ent = btn_enter; m_first = 1'b0;
      if (m_capt) begin
        m_capt = 1'b0; m_offer = 1'b1; m_operand = pack_digits();
        exp_q.push_back('{K_HAND, m_operand});
      end else if (m_offer) begin
        if (e_clr || ready) begin
          if (!ready && exp_q.size() > 0 && exp_q[$].kind == K_HAND) void'(exp_q.pop_back());
          exp_q.push_back('{K_CLEAR, 16'h0});
          m_digits.delete(); m_offer = 1'b0;
        end
      end else if (e_clr) begin
        exp_q.push_back('{K_CLEAR, 16'h0});
        m_digits.delete();
      end else if (e_ent) begin
        if (m_digits.size() != 0) m_capt = 1'b1;
      end else if (e_push) begin
        if (m_digits.size() < MAXD) begin
          m_digits.push_back(sw);
          exp_q.push_back('{K_SHIFT, 16'(sw)});
        end else begin
          exp_q.push_back('{K_REJECT, 16'h0});
        end
      end
    end
  end

  // Monitor: per-cycle state checks plus event scoreboard.
  int          ok;
  bit          obs;
  logic [15:0] ov;
  ev_t         ev;
  always @(negedge clk) begin
    if (!rst) begin
      chk("digit_count", 32'(count), 32'(m_digits.size()));
      chk("operand_valid", 32'(bus.operand_valid), 32'(m_offer));
      chk("operand", 32'(bus.operand), 32'(m_operand));
      chk("strobe_excl", 32'(bus.shift_en & bus.shift_clr), 32'h0);
      obs = 1'b0; ok = -1; ov = '0;
      if (bus.shift_en) begin obs = 1'b1; ok = K_SHIFT; ov = 16'(bus.shift_din); n_shift++; end
      else if (bus.shift_clr) begin obs = 1'b1; ok = K_CLEAR; n_clr++; end
      else if (reject) begin obs = 1'b1; ok = K_REJECT; n_rej++; end
      else if (bus.operand_valid && ready) begin obs = 1'b1; ok = K_HAND; ov = bus.operand; end
      if (bus.operand_valid) n_valid++;
      if (obs) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected actual_kind=%0d required=none at %0t", ok, $time);
        end else begin
          ev = exp_q.pop_front();
          chk("sb_kind", 32'(ok), 32'(ev.kind));
          chk("sb_value", 32'(ov), 32'(ev.val));
        end
      end
      n_chk++;
      if (exp_q.size() > 0 && exp_q[0].kind != K_HAND) begin
        n_err++;
        $display("FAIL sb_missing actual=none required_kind=%0d at %0t", exp_q[0].kind, $time);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [3:0] d);
    sw = d; btn_push = 1'b1; step(1); btn_push = 1'b0; step(2);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; step(1); btn_clear = 1'b0; step(2);
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 20 && !bus.operand_valid; k++) step(1);
    chk(nm, 32'(bus.operand_valid), 32'h1);
  endtask

  int s0, r0, c0, v0;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(bus.operand_valid), 32'h0);
    chk("rst_shift_en", 32'(bus.shift_en), 32'h0);
    chk("rst_reject", 32'(reject), 32'h0);
    step(2); rst = 1'b0; step(2);

    // 1: four digits fill the register
    s0 = n_shift;
    push(4'h3); step(1); push(4'h7); push(4'hA); step(2); push(4'h1);
    chk("t1_shifts", 32'(n_shift - s0), 32'd4);
    chk("t1_count", 32'(count), 32'd4);

    // 2: reject when full, then an offer held for 6 cycles
    s0 = n_shift; r0 = n_rej;
    push(4'hF);
    chk("t2_reject", 32'(n_rej - r0), 32'd1);
    chk("t2_noshift", 32'(n_shift - s0), 32'd0);
    chk("t2_count", 32'(count), 32'd4);
    ready = 1'b0;
    btn_enter = 1'b1; step(1); btn_enter = 1'b0;
    wait_valid("t2_valid_rise");
    v0 = n_valid;
    step(5); ready = 1'b1; step(1); ready = 1'b0;
    chk("t2_valid_cycles", 32'(n_valid - v0), 32'd6);
    chk("t2_valid_after", 32'(bus.operand_valid), 32'h0);
    chk("t2_clr_after", 32'(bus.shift_clr), 32'h1);
    chk("t2_count_after", 32'(count), 32'h0);
    chk("t2_operand", 32'(bus.operand), 32'h37A1);
    step(2);

    // 3: enter while empty is ignored; push+enter together captures, no shift
    btn_enter = 1'b1; step(1); btn_enter = 1'b0; step(4);
    chk("t3_empty_enter", 32'(bus.operand_valid), 32'h0);
    push(4'h5); push(4'h9);
    s0 = n_shift;
    sw = 4'h4; btn_push = 1'b1; btn_enter = 1'b1; step(1);
    btn_push = 1'b0; btn_enter = 1'b0;
    wait_valid("t3_capture");
    chk("t3_noshift", 32'(n_shift - s0), 32'd0);
    chk("t3_operand", 32'(bus.operand), 32'h0059);
    press_clear();
    chk("t3_clear_offer", 32'(bus.operand_valid), 32'h0);

    // 4: all three edges at once -> clear only; push one cycle before enter
    push(4'h1); push(4'h2);
    s0 = n_shift; c0 = n_clr;
    sw = 4'hE; btn_push = 1'b1; btn_enter = 1'b1; btn_clear = 1'b1; step(1);
    btn_push = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; step(3);
    chk("t4_noshift", 32'(n_shift - s0), 32'd0);
    chk("t4_clr", 32'(n_clr - c0), 32'd1);
    chk("t4_count", 32'(count), 32'd0);
    push(4'h8);
    sw = 4'hC; btn_push = 1'b1; step(1);
    btn_push = 1'b0; btn_enter = 1'b1; step(1); btn_enter = 1'b0;
    wait_valid("t4_capture");
    chk("t4_operand", 32'(bus.operand), 32'h008C);

    // 5: async reset mid-offer; held push across release gives no shift
    #3 rst = 1'b1; btn_push = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.operand_valid), 32'h0);
    chk("t5_operand", 32'(bus.operand), 32'h0);
    chk("t5_count", 32'(count), 32'h0);
    step(2); rst = 1'b0;
    s0 = n_shift;
    step(5);
    chk("t5_noshift", 32'(n_shift - s0), 32'd0);
    btn_push = 1'b0; step(2);

    // 6: long hold is one press
    s0 = n_shift;
    sw = 4'h6; btn_push = 1'b1; step(20); btn_push = 1'b0; step(2);
    chk("t6_one_shift", 32'(n_shift - s0), 32'd1);

    // Random activity
    for (int i = 0; i < 800; i++) begin
      sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) btn_push = ~btn_push;
      if ($urandom_range(0, 5) == 0) btn_enter = ~btn_enter;
      if ($urandom_range(0, 13) == 0) btn_clear = ~btn_clear;
      ready = ($urandom_range(0, 3) == 0);
      step(1);
    end
    btn_push = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; ready = 1'b1;
    step(10);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
